rr_sel_arbiter: RTL and testbench
=================================

# rr_sel_arbiter

Round-robin arbiter that shares the team's 4:1 selector among four requesters. Registered one-hot grant and the 2-bit select for the downstream 4:1 selector. A grant is held while its requester keeps `req` high. Fair rotation prevents starvation. The block sits directly in front of the selector and is its only driver of the select lines.

## Interface
- `MAX_BURST`, default 8: maximum consecutive grant cycles per owner when others wait. Used only with the burst-limit option; legal range 1..255.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `req`  in  4  request per requester; index i = requester i.
- `gnt`  out  4  registered one-hot grant, or all zero.
- `sel`  out  2  registered select for the 4:1 selector.
- `busy`  out  1  registered; high while any grant is active.
- `owner`  out  2  registered index of the current or last owner.

## Operation
- The 4:1 selector maps `sel` = 2'b00 to `in[3]`, 01 to `in[2]`, 10 to `in[1]` and 11 to `in[0]`. Therefore `sel` = 3 − owner whenever `gnt` is nonzero.
- The FSM has two states: IDLE and GRANT.
- Rotating priority:
  - A pointer `last` (2 bits) holds the most recently granted index.
  - Search order is last+1, last+2, last+3, last, all mod 4.
  - The first requester with `req` high in that order wins.
- IDLE:
  - If any `req` bit is high, go to GRANT with the winner: `gnt` = one-hot(winner), `owner` = `last` = winner, `busy` = 1.
  - Otherwise stay in IDLE.
- GRANT, holder's `req` still high (and no burst preemption): hold `gnt`, `sel` and `owner` unchanged.
- GRANT, holder's `req` low:
  - Re-arbitrate in the same edge using the updated pointer, so the holder has lowest priority.
  - If a winner exists, hand over with no dead cycle.
  - If no winner exists, go to IDLE: `gnt` = 0, `busy` = 0. `owner` and `sel` keep their last values.
- Simultaneous requests: resolved only by pointer order. No fixed priority exists beyond reset.
- `gnt` is never multi-hot. At most one transition happens per cycle.
- Reset (`rst_n` low at an edge, including mid-grant):
  - State = IDLE.
  - `gnt` = 4'b0000, `busy` = 0, `owner` = 2'd3, `last` = 2'd3, `sel` = 2'b00. Requester 0 has top priority afterwards.
  - The burst counter is cleared.
  - `req` is ignored on the reset edge.

## Timing
- Latency from `req` rise to `gnt` is 1 cycle from IDLE. A request sampled high at edge N gives `gnt` high after edge N.
- Handover: holder `req` sampled low at edge N gives the new `gnt` after edge N. Zero idle cycles between owners.
- Release to idle: 1 cycle. `gnt` is low after the edge where the holder's `req` is sampled low.
- `sel` and `gnt` change on the same edge, so the selector output is valid in the cycle `gnt` is high.
- No combinational path from inputs to outputs.

## Configuration
- `RR_SEL_ARBITER_BURST_LIMIT_EN` defined:
  - An 8-bit counter counts grant cycles for the current owner.
  - When the count reaches `MAX_BURST` and another `req` bit is high, the grant is preempted at that edge as if the holder had released.
  - The counter resets to 1 on every new grant.
  - If no other requester waits, the holder keeps the grant. The counter saturates at `MAX_BURST`.
- Macro undefined: no counter is built, `MAX_BURST` is ignored, and a grant lasts until the holder drops `req`.

## Structure
- Shared package `rr_sel_pkg`:
  - State enum {IDLE, GRANT}.
  - Constants `RR_N` = 4 and `RR_IDX_W` = 2.
  - Function idx_to_sel(idx) = 3 − idx, used by any other block that drives the 4:1 selector.
- One sub-module, `rr_pick`: purely combinational. Inputs are `req[3:0]` and `last[1:0]`. Outputs are `win_valid` and `win_idx[1:0]` in rotating order. The top level holds the FSM, pointer, counter and output registers.

## Test plan
- Reset then `req` = 4'b1111 → after 1 edge `gnt` = 4'b0001, `sel` = 2'b11. Drop `req[0]` → next edge `gnt` = 4'b0010, `sel` = 2'b10.
- Each holder drops `req` in turn with all others held → grants rotate 0,1,2,3,0 with no cycle where `gnt` = 0.
- Single requester `req` = 4'b0100 held 5 cycles then dropped → `gnt` = 4'b0100 and `sel` = 2'b01 for 5 cycles; `busy` low 1 edge after the drop; `owner` stays 2.
- `rst_n` low during a grant to requester 2 → `gnt` = 0, `busy` = 0, `sel` = 2'b00. Then `req` = 4'b0101 → requester 0 is granted.
- With `RR_SEL_ARBITER_BURST_LIMIT_EN` and `MAX_BURST` = 3, `req` = 4'b0011 held → `gnt` pattern 0001 ×3, 0010 ×3, 0001 ×3. With only `req[1]` = 1 → the grant is held indefinitely.
- Without the macro, same stimulus → `gnt` = 4'b0001 for the whole run.

Source files
------------

// File: rtl/rr_sel_pkg.sv
// Shared types, constants and the select-encoding helper for blocks that drive
// the team's 4:1 selector.
package rr_sel_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } rr_state_e;

   localparam int RR_N     = 4;
   localparam int RR_IDX_W = 2;

   // The selector is wired in reverse: sel 0 picks in[3], sel 3 picks in[0].
   function automatic logic [RR_IDX_W-1:0] idx_to_sel(input logic [RR_IDX_W-1:0] idx);
      return 2'd3 - idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority pick: searches last+1, last+2, last+3, last
// and reports the first requester found.
module rr_pick
   import rr_sel_pkg::*;
(
   input  logic [RR_N-1:0]     req,
   input  logic [RR_IDX_W-1:0] last,
   output logic                win_valid,
   output logic [RR_IDX_W-1:0] win_idx
);

   logic [RR_IDX_W-1:0] cand;

   always_comb begin
      win_valid = 1'b0;
      win_idx   = last;
      cand      = last;
      for (int k = 1; k <= RR_N; k++) begin
         cand = last + 2'(k);
         if (!win_valid && req[cand]) begin
            win_valid = 1'b1;
            win_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter in front of the 4:1 selector: registered one-hot grant,
// select, busy and owner. Optional burst limit via RR_SEL_ARBITER_BURST_LIMIT_EN.
module rr_sel_arbiter
   import rr_sel_pkg::*;
#(
   parameter int MAX_BURST = 8
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [RR_N-1:0]     req,
   output logic [RR_N-1:0]     gnt,
   output logic [RR_IDX_W-1:0] sel,
   output logic                busy,
   output logic [RR_IDX_W-1:0] owner,
   output logic                state_dbg
);

   // Handshake: a requester raises req and keeps it high for as long as it
   // wants the selector; gnt[i] high means requester i owns it this cycle,
   // and dropping req is the release, taking effect at the next edge.

   rr_state_e           state_q, state_nxt;
   logic [RR_N-1:0]     gnt_q, gnt_nxt;
   logic [RR_IDX_W-1:0] sel_q, sel_nxt;
   logic                busy_q, busy_nxt;
   logic [RR_IDX_W-1:0] owner_q, owner_nxt;
   logic [RR_IDX_W-1:0] last_q;

   logic                win_valid;
   logic [RR_IDX_W-1:0] win_idx;
   logic                preempt;
   logic                release_now;
   logic                take;

   rr_pick u_pick (
      .req       (req),
      .last      (last_q),
      .win_valid (win_valid),
      .win_idx   (win_idx)
   );

`ifdef RR_SEL_ARBITER_BURST_LIMIT_EN
   logic [7:0] burst_q;

   // Saturates at MAX_BURST so a lone holder never wraps the count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         burst_q <= 8'd0;
      end else if (take) begin
         burst_q <= 8'd1;
      end else if (state_q == GRANT && burst_q < 8'(MAX_BURST)) begin
         burst_q <= burst_q + 8'd1;
      end
   end

   assign preempt = (state_q == GRANT) && (burst_q == 8'(MAX_BURST)) &&
                    ((req & ~(4'b0001 << owner_q)) != 4'b0000);
`else
   assign preempt = 1'b0;
`endif

   // last_q equals the holder during GRANT, so the pick already ranks it last.
   assign release_now = (state_q == GRANT) && (!req[owner_q] || preempt);
   assign take        = ((state_q == IDLE) || release_now) && win_valid;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE:    state_nxt = win_valid ? GRANT : IDLE;
         GRANT:   if (release_now) state_nxt = win_valid ? GRANT : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      gnt_nxt   = gnt_q;
      sel_nxt   = sel_q;
      busy_nxt  = busy_q;
      owner_nxt = owner_q;
      if (take) begin
         gnt_nxt   = 4'b0001 << win_idx;
         sel_nxt   = idx_to_sel(win_idx);
         busy_nxt  = 1'b1;
         owner_nxt = win_idx;
      end else if (state_nxt == IDLE) begin
         gnt_nxt  = 4'b0000;
         busy_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gnt_q   <= 4'b0000;
         sel_q   <= 2'b00;
         busy_q  <= 1'b0;
         owner_q <= 2'd3;
         last_q  <= 2'd3;
      end else begin
         gnt_q   <= gnt_nxt;
         sel_q   <= sel_nxt;
         busy_q  <= busy_nxt;
         owner_q <= owner_nxt;
         if (take) last_q <= win_idx;
      end
   end

   assign gnt       = gnt_q;
   assign sel       = sel_q;
   assign busy      = busy_q;
   assign owner     = owner_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Directed bench for rr_sel_arbiter with hand-computed expectations; the burst
// section expects the pattern matching whether RR_SEL_ARBITER_BURST_LIMIT_EN is set.
module tb_rr_sel_arbiter;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       busy;
   logic [1:0] owner;
   logic       state_dbg;

   int n_checks = 0;
   int n_pass   = 0;
   logic [3:0] exp_q[$];

   rr_sel_arbiter #(.MAX_BURST(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .gnt       (gnt),
      .sel       (sel),
      .busy      (busy),
      .owner     (owner),
      .state_dbg (state_dbg)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Driver tasks: inputs change 1 time unit after the edge, outputs sampled there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_grant(input string tag, input logic [3:0] g, input logic [1:0] s);
      check({tag, "_gnt"}, 32'(gnt), 32'(g));
      check({tag, "_sel"}, 32'(sel), 32'(s));
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 4'b1111;
      step();
      do_reset();
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_owner", 32'(owner), 32'h3);
      check("rst_sel", 32'(sel), 32'h0);
      check("rst_state", 32'(state_dbg), 32'h0);

      // All requesting after reset: requester 0 first, then rotation.
      req = 4'b1111;
      step();
      check_grant("first", 4'b0001, 2'b11);
      check("first_busy", 32'(busy), 32'h1);
      check("first_owner", 32'(owner), 32'h0);
      req = 4'b1110;
      step();
      check_grant("rot1", 4'b0010, 2'b10);
      req = 4'b1101;
      step();
      check_grant("rot2", 4'b0100, 2'b01);
      req = 4'b1011;
      step();
      check_grant("rot3", 4'b1000, 2'b00);
      req = 4'b0111;
      step();
      check_grant("rot0", 4'b0001, 2'b11);
      check("rot0_owner", 32'(owner), 32'h0);

      req = 4'b0000;
      step();
      check("idle_gnt", 32'(gnt), 32'h0);
      check("idle_busy", 32'(busy), 32'h0);
      check("idle_owner", 32'(owner), 32'h0);
      check("idle_sel", 32'(sel), 32'h3);

      // Single requester 2 held 5 cycles then dropped.
      req = 4'b0100;
      for (int i = 0; i < 5; i++) begin
         step();
         check_grant($sformatf("single%0d", i), 4'b0100, 2'b01);
         if (i < 4) check($sformatf("single_owner%0d", i), 32'(owner), 32'h2);
      end
      req = 4'b0000;
      step();
      check("single_rel_busy", 32'(busy), 32'h0);
      check("single_rel_gnt", 32'(gnt), 32'h0);
      check("single_rel_owner", 32'(owner), 32'h2);
      check("single_rel_sel", 32'(sel), 32'h1);

      // Reset in the middle of a grant to requester 2.
      req = 4'b0100;
      step();
      check_grant("pre_rst", 4'b0100, 2'b01);
      rst_n = 1'b0;
      step();
      check("mid_rst_gnt", 32'(gnt), 32'h0);
      check("mid_rst_busy", 32'(busy), 32'h0);
      check("mid_rst_sel", 32'(sel), 32'h0);
      check("mid_rst_owner", 32'(owner), 32'h3);
      rst_n = 1'b1;
      req   = 4'b0101;
      step();
      check_grant("post_rst", 4'b0001, 2'b11);

      // Burst section from a fresh reset with req 0011 held.
      req = 4'b0000;
      do_reset();
`ifdef RR_SEL_ARBITER_BURST_LIMIT_EN
      exp_q = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010,
                4'b0001, 4'b0001, 4'b0001};
`else
      exp_q = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                4'b0001, 4'b0001, 4'b0001};
`endif
      req = 4'b0011;
      for (int i = 0; i < 9; i++) begin
         step();
         check($sformatf("burst%0d", i), 32'(gnt), 32'(exp_q.pop_front()));
      end

      // Lone requester 1 keeps the grant well beyond the burst limit.
      req = 4'b0010;
      for (int i = 0; i < 10; i++) begin
         step();
         check_grant($sformatf("lone%0d", i), 4'b0010, 2'b10);
      end
      check("lone_busy", 32'(busy), 32'h1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
